sv_cosim_lane_narrower: RTL and testbench
=========================================

Name: sv_cosim_lane_narrower

Overview:
- Serial inverse of the cosim sign-extension/abs-value packing: takes one 128-bit packed word holding LANES 8-bit lanes, 12-bit stride, 4-bit don't-care gaps between lanes.
- Narrows each lane back to a 4-bit two's-complement value, saturating on overflow. Two modes: two's-complement input, or magnitude-plus-sign input.
- Processes one lane per cycle behind a valid/ready handshake and emits the packed narrow result plus per-lane saturation flags.
- Sits downstream of wide cosim vector sources as the decode-side checker feed.

Parameters:
- LANES, 6, number of lanes per word.
- IN_W, 8, input lane width.
- OUT_W, 4, output lane width (signed).
- STRIDE, 12, bit stride between input lane LSBs (lane k at in_data[STRIDE*k+IN_W-1 : STRIDE*k]).

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  128  packed lanes; gap bits ignored (may be X/Z).
- in_mode  input  1  0 = lanes are signed two's complement; 1 = lanes are unsigned magnitudes with sign in in_sign.
- in_sign  input  LANES  per-lane sign bit, used only when in_mode=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  LANES*OUT_W  lane k result at [OUT_W*k+OUT_W-1 : OUT_W*k].
- out_sat  output  LANES  bit k set if lane k saturated.

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, lane counter 0. Output reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0.
- Data path: in_data, in_mode and in_sign are captured into internal registers on accept, so input ports may change afterwards.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture the word, clear out_data/out_sat, go to RUN, lane counter=0.
- FSM RUN:
  - in_ready=0.
  - Each cycle, process lane[counter] and write its OUT_W result and sat bit; counter increments.
  - After lane LANES-1, go to DONE.
- FSM DONE:
  - out_valid=1, in_ready=0.
  - out_data and out_sat are held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
  - out_data/out_sat keep their last value until the next accept.
- Latency: accept at edge N; out_valid rises after edge N+LANES (lane results written on edges N+1..N+LANES). Throughput is one word per LANES+2 cycles minimum.
- Mode 0 (signed lane v, range -128..127):
  - v>7 gives 7 with sat=1.
  - v<-8 gives -8 (4'h8) with sat=1.
  - Otherwise the result is v[3:0] with sat=0.
- Mode 1 (unsigned magnitude m, sign s):
  - s=0: m>7 gives 7 with sat=1; otherwise m[3:0].
  - s=1: m>8 gives -8 with sat=1; otherwise (-m)[3:0].
  - m=0 with s=1 gives 0, sat=0. m=8 with s=1 gives 4'h8, sat=0.
- Arithmetic is done at IN_W+1 bits to avoid wrap during compare and negate. No lane's result ever depends on another lane.
- Simultaneous events:
  - in_valid is ignored outside IDLE; no queuing.
  - out_ready is ignored when out_valid=0.
- Reset mid-RUN or mid-DONE aborts the word. No partial result is ever presented with out_valid=1.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, out_data=0, out_sat=0. Assert rst_n low asynchronously between edges -> outputs clear immediately.
- Mode 0 mix: lanes 0..5 = 0x05,0xFD,0x10,0x80,0x07,0xF8, gaps=Z -> out_valid 6 cycles after accept with out_data=24'h8787D5 and out_sat=6'b001100.
- Mode 1 boundaries: all lanes 0x08, in_sign=6'b010101 -> out_data=24'h787878, out_sat=6'b101010. Then all lanes 0x00, in_sign=6'b111111 -> out_data=0, out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0. Raising in_valid with a new word has no effect until the IDLE return.
- Reset mid-operation: pulse rst_n low at the 3rd RUN cycle -> out_valid never asserts for that word, in_ready=1 after reset. A following mode-0 word of all 0x7F yields out_data=24'h777777, out_sat=6'b111111.
- Back-to-back: out_ready tied 1, in_valid tied 1 with alternating words -> one result per 8 cycles, each matching its reference model, no dropped or duplicated words.

Source files
------------

// File: rtl/sv_cosim_lane_narrower.sv
// rtl/sv_cosim_lane_narrower.sv - serial lane narrower with saturation, one lane per cycle
module sv_cosim_lane_narrower #(
  parameter int LANES  = 6,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4,
  parameter int STRIDE = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_data,
  input  logic                   in_mode,
  input  logic [LANES-1:0]       in_sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [LANES*IN_W-1:0]  data_q;
  logic                   mode_q;
  logic [LANES-1:0]       sign_q;
  logic [LANES*IN_W-1:0]  lanes_in;
  logic [OUT_W:0]         lane_res;
  logic                   unused_gap;

  // Gap bits between lanes are never stored; only the lane fields are captured.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lanes_in[k*IN_W +: IN_W] = in_data[STRIDE*k +: IN_W];
  end
  assign unused_gap = ^in_data;

  // Returns {sat, value}; widened by one bit so negating 255 or comparing cannot wrap.
  function automatic logic [OUT_W:0] narrow(input logic [IN_W-1:0] raw,
                                            input logic mode,
                                            input logic sgn);
    logic signed [IN_W:0] v;
    if (!mode)
      v = $signed({raw[IN_W-1], raw});
    else if (sgn)
      v = -$signed({1'b0, raw});
    else
      v = $signed({1'b0, raw});
    if (v > MAXV)
      return {1'b1, MAXV[OUT_W-1:0]};
    else if (v < MINV)
      return {1'b1, MINV[OUT_W-1:0]};
    else
      return {1'b0, v[OUT_W-1:0]};
  endfunction

  always_comb begin
    lane_res = narrow(data_q[cnt*IN_W +: IN_W], mode_q, sign_q[cnt]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      data_q    <= '0;
      mode_q    <= 1'b0;
      sign_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= lanes_in;
            mode_q   <= in_mode;
            sign_q   <= in_sign;
            out_data <= '0;
            out_sat  <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          out_data[cnt*OUT_W +: OUT_W] <= lane_res[OUT_W-1:0];
          out_sat[cnt]                 <= lane_res[OUT_W];
          if (cnt == LAST) begin
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sv_cosim_lane_narrower.sv
// tb/tb_sv_cosim_lane_narrower.sv - directed bench with behavioural word model for the lane narrower
module tb_sv_cosim_lane_narrower;

  localparam int LANES = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_mode = 1'b0;
  logic [5:0]   in_sign = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [23:0]  out_data;
  logic [5:0]   out_sat;

  sv_cosim_lane_narrower dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic        inflight = 1'b0;
  int          age = 0;
  logic [29:0] exp_w = '0;
  int          dut_outs = 0;

  // Whole-word reference: {sat[5:0], data[23:0]} from plain integer clamping.
  function automatic logic [29:0] ref_word(input logic [127:0] d, input logic m, input logic [5:0] s);
    logic [23:0] od;
    logic [5:0]  os;
    logic [7:0]  b;
    int          v;
    od = '0;
    os = '0;
    for (int k = 0; k < LANES; k++) begin
      b = d[12*k +: 8];
      if (!m) v = $signed(b);
      else    v = s[k] ? -int'(b) : int'(b);
      if (v > 7) begin
        v = 7;
        os[k] = 1'b1;
      end else if (v < -8) begin
        v = -8;
        os[k] = 1'b1;
      end
      od[4*k +: 4] = v[3:0];
    end
    return {os, od};
  endfunction

  function automatic logic [127:0] pack(input logic [47:0] lanes);
    logic [127:0] d;
    d = {128{1'bz}};
    for (int k = 0; k < LANES; k++) d[12*k +: 8] = lanes[8*k +: 8];
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of the handshake timing: one word in flight, results LANES edges after accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      age      <= 0;
    end else begin
      if (inflight) begin
        if (age >= LANES && out_ready) inflight <= 1'b0;
        else                           age <= age + 1;
      end else if (in_valid) begin
        inflight <= 1'b1;
        age      <= 0;
        exp_w    <= ref_word(in_data, in_mode, in_sign);
      end
      if (out_valid && out_ready) dut_outs <= dut_outs + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_sat", 32'(out_sat), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!inflight));
      chk("out_valid", 32'(out_valid), 32'(inflight && age >= LANES));
      if (inflight && age >= LANES) begin
        chk("out_data", 32'(out_data), 32'(exp_w[23:0]));
        chk("out_sat", 32'(out_sat), 32'(exp_w[29:24]));
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic m, input logic [5:0] s,
                      output logic [23:0] od, output logic [5:0] os, output int lat);
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_sign  = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_mode  = ~m;
    in_sign  = ~s;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    od = out_data;
    os = out_sat;
  endtask

  logic [23:0]  od, held;
  logic [5:0]   os;
  int           lat, n0;
  logic [127:0] bw [3];
  logic         bm [3];
  logic [5:0]   bs [3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'($urandom);
      in_mode  = 1'($urandom);
      in_sign  = 6'($urandom);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;

    chk("model_mix", 32'(ref_word(pack(48'hF8_07_80_10_FD_05), 1'b0, 6'b0)), {2'b0, 6'b001100, 24'h8787D5});
    chk("model_m1_8", 32'(ref_word(pack(48'h08_08_08_08_08_08), 1'b1, 6'b010101)), {2'b0, 6'b101010, 24'h787878});
    chk("model_m1_9neg", 32'(ref_word(pack(48'h00_00_00_00_00_09), 1'b1, 6'b000001)), {2'b0, 6'b000001, 24'h000008});

    send(pack(48'hF8_07_80_10_FD_05), 1'b0, 6'b000000, od, os, lat);
    chk("mix_latency", 32'(lat), 32'd6);
    chk("mix_data", 32'(od), 32'h8787D5);
    chk("mix_sat", 32'(os), 32'b001100);

    send(pack(48'h08_08_08_08_08_08), 1'b1, 6'b010101, od, os, lat);
    chk("m1_8_data", 32'(od), 32'h787878);
    chk("m1_8_sat", 32'(os), 32'b101010);

    send(pack(48'h00_00_00_00_00_00), 1'b1, 6'b111111, od, os, lat);
    chk("m1_0_data", 32'(od), 32'h000000);
    chk("m1_0_sat", 32'(os), 32'b000000);

    out_ready = 1'b0;
    send(pack(48'h81_7F_09_F7_00_FF), 1'b1, 6'b110011, od, os, lat);
    held = od;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pack(48'h11_22_33_44_55_66);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'(held));
      chk("bp_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    @(negedge clk);
    in_data  = pack(48'h7F_7F_7F_7F_7F_7F);
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("partial_before_reset", 32'(out_data), 32'h000077);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send(pack(48'h7F_7F_7F_7F_7F_7F), 1'b0, 6'b000000, od, os, lat);
    chk("post_rst_data", 32'(od), 32'h777777);
    chk("post_rst_sat", 32'(os), 32'b111111);

    bw[0] = pack(48'hF8_07_80_10_FD_05); bm[0] = 1'b0; bs[0] = 6'b000000;
    bw[1] = pack(48'h81_7F_09_F7_00_FF); bm[1] = 1'b1; bs[1] = 6'b110011;
    bw[2] = pack(48'h90_6F_F9_08_C3_02); bm[2] = 1'b0; bs[2] = 6'b101010;
    @(negedge clk);
    n0 = dut_outs;
    for (int i = 0; i < 40; i++) begin
      in_data  = bw[i % 3];
      in_mode  = bm[i % 3];
      in_sign  = bs[i % 3];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_count", 32'(dut_outs - n0), 32'd5);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
